pll_acq_sequencer: RTL

//  Acquisition/lock sequencer for the 50 MHz NCO-based software PLL.
//  - Watches synchronized feedback edges and phase-detector slew requests.
//  - Moves the loop through IDLE -> ACQUIRE -> LOCKED, with HOLDOVER on input faults.
//  - Drives the loop's hold (freeze frequency) and restore (reload lookback frequency) controls.
//  - Drives the lock/status indicators for the LED/7-seg display path.

---
 rtl/pll_seq_pkg.sv | 29 ++
 rtl/pll_period_monitor.sv | 63 ++++++
 rtl/pll_acq_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding, defaults and helpers for the PLL acquisition sequencer
package pll_seq_pkg;

   // Sequencer states; the numeric values are visible on the state port
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2,
      HOLDOVER = 2'd3
   } seq_state_t;

   // Default timing for a 50 MHz clk_50 and a 50..210 kHz feedback half-period
   localparam int PERIOD_MIN_CYC_DEF = 119;
   localparam int PERIOD_MAX_CYC_DEF = 500;
   localparam int LOCK_ERR_MAX_DEF   = 4;
   localparam int LOCK_EDGES_DEF     = 16;
   localparam int HOLD_CYC_DEF       = 50000;

   // 8-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // 16-bit increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pll_period_monitor.sv
// rtl/pll_period_monitor.sv - feedback period and phase-error qualifier producing too_fast/too_slow/good/bad
module pll_period_monitor
   import pll_seq_pkg::*;
#(
   parameter int PERIOD_MIN_CYC = PERIOD_MIN_CYC_DEF,
   parameter int PERIOD_MAX_CYC = PERIOD_MAX_CYC_DEF,
   parameter int LOCK_ERR_MAX   = LOCK_ERR_MAX_DEF
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic fb_edge,
   input  logic slew_fast,
   input  logic slew_slow,
   output logic too_fast,
   output logic too_slow,
   output logic good,
   output logic bad
);

   localparam logic [15:0] MIN_C = 16'(PERIOD_MIN_CYC);
   localparam logic [15:0] MAX_C = 16'(PERIOD_MAX_CYC);
   localparam logic [15:0] ERR_C = 16'(LOCK_ERR_MAX);

   logic [15:0] per_ctr;
   logic [15:0] err_ctr;
   logic        slew_active;
   logic        period_ok;

   // Opposing requests cancel: only a one-sided request is a phase error
   assign slew_active = slew_fast ^ slew_slow;

   // Cycles since the last feedback edge; parks at the max so a lost input reports once
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         per_ctr <= '0;
      end else if (fb_edge) begin
         per_ctr <= '0;
      end else if (per_ctr < MAX_C) begin
         per_ctr <= per_ctr + 16'd1;
      end
   end

   // Phase-error cycles accumulated over the current half-period
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         err_ctr <= '0;
      end else if (fb_edge) begin
         err_ctr <= '0;
      end else if (slew_active) begin
         err_ctr <= sat_inc16(err_ctr);
      end
   end

   // Qualify the edge arriving this cycle against the period and error limits
   always_comb begin
      too_fast  = fb_edge && (per_ctr < MIN_C);
      too_slow  = !fb_edge && (per_ctr == MAX_C - 16'd1);
      period_ok = fb_edge && !too_fast && (per_ctr < MAX_C);
      good      = period_ok && (err_ctr <= ERR_C);
      bad       = period_ok && !good;
   end

endmodule

// File: rtl/pll_acq_sequencer.sv
// rtl/pll_acq_sequencer.sv - IDLE/ACQUIRE/LOCKED/HOLDOVER sequencer for the NCO software PLL; PLL_SEQ_STATS_EN enables the lock-loss counter
module pll_acq_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PERIOD_MIN_CYC = PERIOD_MIN_CYC_DEF,
   parameter int PERIOD_MAX_CYC = PERIOD_MAX_CYC_DEF,
   parameter int LOCK_ERR_MAX   = LOCK_ERR_MAX_DEF,
   parameter int LOCK_EDGES     = LOCK_EDGES_DEF,
   parameter int HOLD_CYC       = HOLD_CYC_DEF
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       fb_edge,
   input  logic       slew_fast,
   input  logic       slew_slow,
   input  logic       force_hold,
   output logic       hold,
   output logic       restore,
   output logic       locked,
   output logic [1:0] state,
   output logic [7:0] loss_cnt
);

   localparam int                HOLD_W      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYC - 1);
   localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_EDGES - 1);

   seq_state_t        st;
   logic [7:0]        good_cnt;
   logic [HOLD_W-1:0] hold_tmr;

   logic too_fast;
   logic too_slow;
   logic good;
   logic bad;
   logic period_ok;
   logic fault;

   pll_period_monitor #(
      .PERIOD_MIN_CYC (PERIOD_MIN_CYC),
      .PERIOD_MAX_CYC (PERIOD_MAX_CYC),
      .LOCK_ERR_MAX   (LOCK_ERR_MAX)
   ) u_mon (
      .clk_50    (clk_50),
      .rst_n     (rst_n),
      .fb_edge   (fb_edge),
      .slew_fast (slew_fast),
      .slew_slow (slew_slow),
      .too_fast  (too_fast),
      .too_slow  (too_slow),
      .good      (good),
      .bad       (bad)
   );

   // Any period violation or the operator override outranks edge quality
   assign period_ok = good || bad;
   assign fault     = too_fast || too_slow || force_hold;
   assign state     = st;

   // Sequencer FSM; hold/locked/restore are registered alongside the state
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         hold     <= 1'b1;
         restore  <= 1'b0;
         locked   <= 1'b0;
         good_cnt <= '0;
         hold_tmr <= '0;
      end else begin
         restore <= 1'b0;
         case (st)
            IDLE: begin
               if (period_ok && !force_hold) begin
                  st       <= ACQUIRE;
                  hold     <= 1'b0;
                  good_cnt <= '0;
               end
            end
            ACQUIRE: begin
               if (fault) begin
                  st       <= HOLDOVER;
                  hold     <= 1'b1;
                  locked   <= 1'b0;
                  restore  <= 1'b1;
                  hold_tmr <= HOLD_RELOAD;
               end else if (good) begin
                  good_cnt <= sat_inc8(good_cnt);
                  if (good_cnt == LOCK_LAST) begin
                     st     <= LOCKED;
                     locked <= 1'b1;
                  end
               end else if (bad) begin
                  good_cnt <= '0;
               end
            end
            LOCKED: begin
               if (fault) begin
                  st       <= HOLDOVER;
                  hold     <= 1'b1;
                  locked   <= 1'b0;
                  restore  <= 1'b1;
                  hold_tmr <= HOLD_RELOAD;
               end else if (bad) begin
                  st       <= ACQUIRE;
                  locked   <= 1'b0;
                  good_cnt <= '0;
               end
            end
            HOLDOVER: begin
               // A fresh fault restarts the wait but never re-issues restore
               if (fault) begin
                  hold_tmr <= HOLD_RELOAD;
               end else if (hold_tmr == '0) begin
                  st <= IDLE;
               end else begin
                  hold_tmr <= hold_tmr - 1'b1;
               end
            end
            default: begin
               st     <= IDLE;
               hold   <= 1'b1;
               locked <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLL_SEQ_STATS_EN
   logic lock_drop;

   // In LOCKED every fault or bad edge leaves the state, so this marks each lock loss
   assign lock_drop = (st == LOCKED) && (fault || bad);

   // Saturating count of lock losses for the status display
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt <= '0;
      end else if (lock_drop) begin
         loss_cnt <= sat_inc8(loss_cnt);
      end
   end
`else
   assign loss_cnt = 8'd0;
`endif

endmodule
